// File: rtl/demultiplexor16bits_1x2.sv
// demultiplexor16bits_1x2: routes a 16-bit stream to two independently buffered channels (A/B).
// Optional delivery counters are enabled with macro DEMUX16_CONTADORES_EN.
module demultiplexor16bits_1x2 #(
    parameter int ANCHO = 16,
    parameter int PROF  = 4
) (
    input  logic             Reloj,
    input  logic             Reset_n,
    input  logic [ANCHO-1:0] Entrada,
    input  logic             Seleccion,
    input  logic             EntValido,
    output logic             EntListo,
    output logic [ANCHO-1:0] SalidaA,
    output logic             ValidoA,
    input  logic             ListoA,
    output logic [ANCHO-1:0] SalidaB,
    output logic             ValidoB,
    input  logic             ListoB,
    output logic [15:0]      CuentaA,
    output logic [15:0]      CuentaB
);
    localparam int PW = $clog2(PROF);
    typedef enum logic [1:0] {VACIO, PARCIAL, LLENO} estado_t;
    logic [1:0]       w_push, w_pop, w_lleno, w_valido, w_listo;
    logic [ANCHO-1:0] w_salida [2];
    logic [15:0]      w_cuenta [2];
    assign w_listo  = {ListoB, ListoA};
    assign EntListo = Seleccion ? ~w_lleno[1] : ~w_lleno[0];
    for (genvar c = 0; c < 2; c++) begin : g_canal
        logic [ANCHO-1:0] r_mem [PROF];
        logic [PW-1:0]    r_rd, r_wr;
        logic [PW:0]      r_ocup, w_ocup_sig;
        estado_t          r_estado, w_estado_sig;
        assign w_push[c]   = EntValido & EntListo & (Seleccion == 1'(c));
        assign w_pop[c]    = w_valido[c] & w_listo[c];
        assign w_lleno[c]  = r_ocup == (PW+1)'(PROF);
        assign w_valido[c] = r_estado != VACIO;
        // Head is forced to zero when empty so stale storage never shows on the output.
        assign w_salida[c] = w_valido[c] ? r_mem[r_rd] : '0;
        always_comb begin
            w_ocup_sig   = r_ocup + (PW+1)'(w_push[c]) - (PW+1)'(w_pop[c]);
            w_estado_sig = r_estado;
            if (w_push[c] != w_pop[c])
                w_estado_sig = (w_ocup_sig == '0) ? VACIO :
                               (w_ocup_sig == (PW+1)'(PROF)) ? LLENO : PARCIAL;
        end
        always_ff @(posedge Reloj) begin
            if (!Reset_n) begin
                r_rd     <= '0;
                r_wr     <= '0;
                r_ocup   <= '0;
                r_estado <= VACIO;
            end else begin
                if (w_push[c]) begin
                    r_mem[r_wr] <= Entrada;
                    r_wr        <= r_wr + 1'b1;
                end
                if (w_pop[c])
                    r_rd <= r_rd + 1'b1;
                r_ocup   <= w_ocup_sig;
                r_estado <= w_estado_sig;
            end
        end
`ifdef DEMUX16_CONTADORES_EN
        logic [15:0] r_cuenta;
        always_ff @(posedge Reloj) begin
            if (!Reset_n)
                r_cuenta <= '0;
            else if (w_pop[c] && r_cuenta != 16'hFFFF)
                r_cuenta <= r_cuenta + 16'd1;
        end
        assign w_cuenta[c] = r_cuenta;
`else
        assign w_cuenta[c] = '0;
`endif
    end
    assign SalidaA = w_salida[0];
    assign SalidaB = w_salida[1];
    assign ValidoA = w_valido[0];
    assign ValidoB = w_valido[1];
    assign CuentaA = w_cuenta[0];
    assign CuentaB = w_cuenta[1];
endmodule

// File: tb/tb_demultiplexor16bits_1x2.sv
// tb_demultiplexor16bits_1x2: directed vectors against hand-computed results for the A/B demultiplexor.
module tb_demultiplexor16bits_1x2;
    logic        Reloj = 0, Reset_n = 0, Seleccion = 0, EntValido = 0, EntListo;
    logic        ValidoA, ValidoB, ListoA = 0, ListoB = 0;
    logic [15:0] Entrada = '0, SalidaA, SalidaB, CuentaA, CuentaB;
    int n_vec = 0, n_err = 0;

    demultiplexor16bits_1x2 dut (
        .Reloj(Reloj), .Reset_n(Reset_n), .Entrada(Entrada), .Seleccion(Seleccion),
        .EntValido(EntValido), .EntListo(EntListo),
        .SalidaA(SalidaA), .ValidoA(ValidoA), .ListoA(ListoA),
        .SalidaB(SalidaB), .ValidoB(ValidoB), .ListoB(ListoB),
        .CuentaA(CuentaA), .CuentaB(CuentaB)
    );

    always #5 Reloj = ~Reloj;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vec++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge Reloj);
        #1;
    endtask

    initial begin
        ciclo();
        ciclo();
        Reset_n = 1;
        #1;
        chequear("rst_entlisto", EntListo, 1);
        chequear("rst_validoA", ValidoA, 0);
        chequear("rst_validoB", ValidoB, 0);
        chequear("rst_salidaA", SalidaA, 16'h0000);
        chequear("rst_salidaB", SalidaB, 16'h0000);
        chequear("rst_cuentaA", CuentaA, 16'h0000);
        chequear("rst_cuentaB", CuentaB, 16'h0000);

        ListoA = 1; ListoB = 1;
        EntValido = 1; Seleccion = 0; Entrada = 16'h000F;
        ciclo();
        chequear("a_first_data", SalidaA, 16'h000F);
        chequear("a_first_valid", ValidoA, 1);
        Seleccion = 1; Entrada = 16'h0007;
        ciclo();
        chequear("b_first_data", SalidaB, 16'h0007);
        chequear("b_first_valid", ValidoB, 1);
        chequear("a_popped", ValidoA, 0);
        EntValido = 0;
        ciclo();
        chequear("b_popped", ValidoB, 0);

        ListoA = 0; ListoB = 0; Seleccion = 0; EntValido = 1;
        for (int i = 1; i <= 4; i++) begin
            Entrada = 16'(16'hA000 + i);
            ciclo();
        end
        EntValido = 0;
        #1;
        chequear("full_head", SalidaA, 16'hA001);
        chequear("full_listo_sel0", EntListo, 0);
        Seleccion = 1;
        #1;
        chequear("full_listo_sel1", EntListo, 1);
        EntValido = 1; Entrada = 16'hB001;
        ciclo();
        chequear("b_pass_valid", ValidoB, 1);
        chequear("b_pass_data", SalidaB, 16'hB001);
        Seleccion = 0; Entrada = 16'hDEAD;
        #1;
        chequear("full_reject", EntListo, 0);
        ciclo();
        EntValido = 0;

        ListoA = 1; ListoB = 1;
        for (int i = 1; i <= 4; i++) begin
            chequear("drain_data", SalidaA, 32'(16'hA000 + i));
            chequear("drain_valid", ValidoA, 1);
            ciclo();
        end
        chequear("drain_emptyA", ValidoA, 0);
        chequear("drain_emptyB", ValidoB, 0);

        Seleccion = 0; EntValido = 1; Entrada = 16'hC000;
        ciclo();
        for (int i = 1; i <= 10; i++) begin
            chequear("pp_data", SalidaA, 32'(16'hC000 + i - 1));
            chequear("pp_listo", EntListo, 1);
            Entrada = 16'(16'hC000 + i);
            ciclo();
        end
        EntValido = 0;
        #1;
        chequear("pp_last", SalidaA, 16'hC00A);
        ciclo();
        chequear("pp_empty", ValidoA, 0);
`ifdef DEMUX16_CONTADORES_EN
        chequear("cnt_A16", CuentaA, 16);
        chequear("cnt_B2", CuentaB, 2);
`else
        chequear("cnt_tied_A", CuentaA, 0);
        chequear("cnt_tied_B", CuentaB, 0);
`endif

        ListoA = 0; EntValido = 1; Seleccion = 0;
        for (int i = 1; i <= 3; i++) begin
            Entrada = 16'(16'hE000 + i);
            ciclo();
        end
        EntValido = 0;
        chequear("pre_rst_valid", ValidoA, 1);
        Reset_n = 0;
        ciclo();
        chequear("mid_rst_validA", ValidoA, 0);
        chequear("mid_rst_validB", ValidoB, 0);
        chequear("mid_rst_salidaA", SalidaA, 16'h0000);
        chequear("mid_rst_listo", EntListo, 1);
        chequear("mid_rst_cntA", CuentaA, 0);
        Reset_n = 1; ListoA = 1;
        ciclo();
        ciclo();
        chequear("post_rst_noreappear", ValidoA, 0);

        EntValido = 1; Seleccion = 0;
        for (int i = 1; i <= 5; i++) begin
            Entrada = 16'(16'hF000 + i);
            ciclo();
            chequear("stream_data", SalidaA, 32'(16'hF000 + i));
            chequear("stream_valid", ValidoA, 1);
        end
        EntValido = 0;
        ciclo();
        chequear("stream_empty", ValidoA, 0);
`ifdef DEMUX16_CONTADORES_EN
        chequear("cnt_A5", CuentaA, 5);
`else
        chequear("cnt_tied_A_end", CuentaA, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
